// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: decodes ALUOp/funct into {ainvert,binvert,op}, then runs the
// operation LSB-first through a 1-bit slice, one bit per clock, with a start/busy/done handshake.
module alu_serial_sequencer #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       ALUOp,
   input  logic [3:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [3:0]       alu_ctrl,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carryout,
   output logic             error
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             cout_q, cout_d;
   logic             error_q, error_d;

   logic [3:0]       dec_ctrl;
   logic             dec_illegal;
   logic             ai, bi, slice_r, slice_carry;
   logic             last_bit;

   // Control word is {ainvert, binvert, op[1:0]}; unknown encodings flag an error.
   always_comb begin
      // NOTE: every combinational output gets a default before the case so no latch is inferred.
      dec_ctrl    = 4'b0000;
      dec_illegal = 1'b0;
      case (ALUOp)
         2'b00: dec_ctrl = 4'b0010;
         2'b01: dec_ctrl = 4'b0110;
         2'b10: begin
            case (funct)
               4'b0000: dec_ctrl = 4'b0010;
               4'b1000: dec_ctrl = 4'b0110;
               4'b0111: dec_ctrl = 4'b0000;
               4'b0110: dec_ctrl = 4'b0001;
               default: dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // One-bit ALU slice operating on bit cnt_q of the latched operands.
   always_comb begin
      ai          = a_q[cnt_q] ^ ctrl_q[3];
      bi          = b_q[cnt_q] ^ ctrl_q[2];
      slice_carry = (ai & bi) | (ai & carry_q) | (bi & carry_q);
      case (ctrl_q[1:0])
         2'b00:   slice_r = ai & bi;
         2'b01:   slice_r = ai | bi;
         2'b10:   slice_r = ai ^ bi ^ carry_q;
         default: slice_r = 1'b0;
      endcase
   end

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      ctrl_d   = ctrl_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      result_d = result_q;
      zero_d   = zero_q;
      cout_d   = cout_q;
      error_d  = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               ctrl_d   = dec_ctrl;
               carry_d  = dec_ctrl[2];
               cnt_d    = '0;
               result_d = '0;
               if (dec_illegal) begin
                  state_d = S_DONE;
                  zero_d  = 1'b1;
                  cout_d  = 1'b0;
                  error_d = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            result_d[cnt_q] = slice_r;
            if (ctrl_q[1:0] == 2'b10) begin
               carry_d = slice_carry;
            end
            if (last_bit) begin
               // Flags are taken from the completed result, including the bit written this cycle.
               state_d = S_DONE;
               zero_d  = ~|result_d;
               cout_d  = (ctrl_q[1:0] == 2'b10) ? carry_d : 1'b0;
               error_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         cout_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ctrl_q   <= ctrl_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         cout_q   <= cout_d;
         error_q  <= error_d;
      end
   end

   assign alu_ctrl = ctrl_q;
   assign busy     = (state_q == S_RUN);
   assign done     = (state_q == S_DONE);
   assign result   = result_q;
   assign zero     = zero_q;
   assign carryout = cout_q;
   assign error    = error_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Scoreboard bench for alu_serial_sequencer: directed ops push expected responses; a monitor
// pops and compares on every done pulse, also checking busy length and unexpected dones.
module tb_alu_serial_sequencer;

   localparam int W = 64;

   typedef struct {
      logic [3:0]   ctrl;
      logic         chk_ctrl;
      logic [W-1:0] res;
      logic         z;
      logic         c;
      logic         e;
      int           busy_cyc;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [1:0]   ALUOp;
   logic [3:0]   funct;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   alu_ctrl;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         zero;
   logic         carryout;
   logic         error;

   int   tests = 0;
   int   fails = 0;
   int   busy_cnt = 0;
   exp_t sb[$];

   alu_serial_sequencer #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .ALUOp    (ALUOp),
      .funct    (funct),
      .a        (a),
      .b        (b),
      .alu_ctrl (alu_ctrl),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .zero     (zero),
      .carryout (carryout),
      .error    (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares every done against the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_cnt = 0;
         end else begin
            if (busy) busy_cnt++;
            if (done) begin
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_done: got done=1 with empty scoreboard, expected no done");
               end else begin
                  e = sb.pop_front();
                  check("result", result, e.res);
                  check("zero", W'(zero), W'(e.z));
                  check("carryout", W'(carryout), W'(e.c));
                  check("error", W'(error), W'(e.e));
                  check("busy_cycles", W'(busy_cnt), W'(e.busy_cyc));
                  if (e.chk_ctrl) check("alu_ctrl", W'(alu_ctrl), W'(e.ctrl));
               end
               busy_cnt = 0;
            end
         end
      end
   end

   function automatic exp_t mk(input logic [3:0] ctrl, input logic chk, input logic [W-1:0] res,
                               input logic z, input logic c, input logic e, input int bc);
      exp_t x;
      x.ctrl = ctrl; x.chk_ctrl = chk; x.res = res; x.z = z; x.c = c; x.e = e; x.busy_cyc = bc;
      return x;
   endfunction

   // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
   task automatic run_op(input logic [1:0] op, input logic [3:0] fn, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input exp_t e, input int inject_at);
      int lat;
      sb.push_back(e);
      start = 1'b1; ALUOp = op; funct = fn; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; a = ~av; b = ~bv;
      lat = 0;
      while (!done && lat < 200) begin
         if (lat == inject_at) begin
            start = 1'b1; ALUOp = 2'b01; a = 64'hDEAD; b = 64'h1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check("done_latency", W'(lat), W'(e.busy_cyc));
      @(negedge clk);
      check("done_one_cycle", W'(done), '0);
      check("busy_after_done", W'(busy), '0);
      check("result_held", result, e.res);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ALUOp = 2'b00; funct = 4'b0000; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("rst_alu_ctrl", W'(alu_ctrl), '0);
      check("rst_busy", W'(busy), '0);
      check("rst_done", W'(done), '0);
      check("rst_result", result, '0);
      check("rst_flags", W'({zero, carryout, error}), '0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(2'b00, 4'b0000, 64'd5, 64'd3, mk(4'b0010, 1, 64'd8, 0, 0, 0, W), -1);
      run_op(2'b01, 4'b0000, 64'd7, 64'd7, mk(4'b0110, 1, 64'd0, 1, 1, 0, W), -1);
      run_op(2'b01, 4'b0000, 64'd3, 64'd7,
             mk(4'b0110, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, W), -1);
      run_op(2'b10, 4'b0111, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
             mk(4'b0000, 1, 64'hF000_F000_F000_F000, 0, 0, 0, W), -1);
      run_op(2'b10, 4'b0110, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
             mk(4'b0001, 1, 64'hFFF0_FFF0_FFF0_FFF0, 0, 0, 0, W), -1);
      run_op(2'b00, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, mk(4'b0010, 1, 64'd0, 1, 1, 0, W), -1);
      run_op(2'b10, 4'b0000, 64'h1234, 64'h1, mk(4'b0010, 1, 64'h1235, 0, 0, 0, W), -1);
      run_op(2'b10, 4'b1000, 64'd10, 64'd3, mk(4'b0110, 1, 64'd7, 0, 1, 0, W), -1);

      // Spurious start during RUN must be ignored.
      run_op(2'b00, 4'b0000, 64'd100, 64'd23, mk(4'b0010, 1, 64'd123, 0, 0, 0, W), 10);

      // Illegal encodings complete immediately with error set.
      run_op(2'b11, 4'b0000, 64'd9, 64'd9, mk(4'b0000, 0, 64'd0, 1, 0, 1, 0), -1);
      run_op(2'b10, 4'b0001, 64'd9, 64'd9, mk(4'b0000, 0, 64'd0, 1, 0, 1, 0), -1);

      // Abort mid-RUN: outputs clear at once and no done follows.
      start = 1'b1; ALUOp = 2'b00; a = 64'd5; b = 64'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("busy_before_abort", W'(busy), W'(1));
      rst_n = 1'b0;
      #1;
      check("abort_alu_ctrl", W'(alu_ctrl), '0);
      check("abort_busy_done", W'({busy, done}), '0);
      check("abort_result", result, '0);
      check("abort_flags", W'({zero, carryout, error}), '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 10) @(negedge clk);
      check("idle_after_abort", W'(busy), '0);

      run_op(2'b01, 4'b0000, 64'd0, 64'd0, mk(4'b0110, 1, 64'd0, 1, 1, 0, W), -1);
      run_op(2'b00, 4'b0000, 64'd5, 64'd3, mk(4'b0010, 1, 64'd8, 0, 0, 0, W), -1);

      repeat (3) @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
